// File: rtl/muldiv_pkg.sv
// Shared types and constants for the M-extension multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_e;

  localparam logic [63:0] MIN_NEG64 = 64'h8000_0000_0000_0000;
  localparam logic [31:0] MIN_NEG32 = 32'h8000_0000;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_div_iter.sv
// Restoring divider on unsigned magnitudes, one quotient bit per cycle.
// The start cycle already retires the first bit, so n_bits cycles total.
module muldiv_div_iter #(
  parameter int W  = 64,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] n_bits,
  input  logic [W-1:0]  dividend,
  input  logic [W-1:0]  divisor,
  output logic          done,
  output logic [W-1:0]  quo,
  output logic [W-1:0]  rem
);
  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt;
  logic [W-1:0]  src_r, src_q, src_d, rem_n, quo_n;
  logic [W:0]    rs, diff;
  logic          ge;

  always_comb begin
    // Short operands are pre-shifted so their MSB is the first bit consumed
    src_r = start ? '0 : rem_q;
    src_q = start ? (dividend << (CW'(W) - n_bits)) : quo_q;
    src_d = start ? divisor : dvs_q;
    rs    = {src_r, src_q[W-1]};
    diff  = rs - {1'b0, src_d};
    ge    = (rs >= {1'b0, src_d});
    rem_n = ge ? diff[W-1:0] : rs[W-1:0];
    quo_n = {src_q[W-2:0], ge};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt   <= '0;
    end else if (start) begin
      dvs_q <= divisor;
      cnt   <= n_bits - CW'(1);
      rem_q <= rem_n;
      quo_q <= quo_n;
    end else if (cnt != '0) begin
      cnt   <= cnt - CW'(1);
      rem_q <= rem_n;
      quo_q <= quo_n;
    end
  end

  assign done = (cnt == '0);
  assign quo  = quo_q;
  assign rem  = rem_q;

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle RV M-extension unit: retimed multiplier plus iterative divider,
// valid/ready on both sides, one operation in flight.
module alu_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);
  localparam int CW  = $clog2(XLEN + 1);
  localparam int MCW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [XLEN-1:0] MIN_X = (XLEN == 64) ? XLEN'(MIN_NEG64) : XLEN'(MIN_NEG32);
  localparam logic [XLEN-1:0] MIN_W = XLEN'(sext32(MIN_NEG32));

  function automatic logic [XLEN-1:0] wfix(input logic [XLEN-1:0] v, input logic w);
    return w ? XLEN'(sext32(v[31:0])) : v;
  endfunction

  muldiv_state_e    state;
  muldiv_op_e       op_q;
  logic             word_q, is_rem_q, sa_q, neg_q;
  logic [TAG_W-1:0] tag_q;
  logic [MCW-1:0]   cnt;

  logic            is_div, div_signed, err_in, a_msign, b_msign;
  logic [XLEN-1:0] a_w, b_w;

  assign in_ready   = (state == ST_IDLE);
  assign is_div     = in_op[2];
  assign div_signed = in_op[2] & ~in_op[0];
  assign err_in     = in_word & ((XLEN == 32) | (~in_op[2] & (in_op[1:0] != 2'b00)));

  always_comb begin
    a_w = in_a;
    b_w = in_b;
    if (in_word) begin
      if (is_div & in_op[0]) begin
        a_w = XLEN'(in_a[31:0]);
        b_w = XLEN'(in_b[31:0]);
      end else begin
        a_w = XLEN'(sext32(in_a[31:0]));
        b_w = XLEN'(sext32(in_b[31:0]));
      end
    end
  end

  // Multiply: full-width product from the request, then MUL_LAT-1 retiming stages
  logic [2*XLEN-1:0] pa, pb, prod_c, prod_r;
  muldiv_op_e        mop;
  logic              mword;
  logic [XLEN-1:0]   mul_res;

  assign a_msign = (in_op != OP_MULHU);
  assign b_msign = (in_op == OP_MUL) | (in_op == OP_MULH);
  assign pa      = {{XLEN{a_msign & a_w[XLEN-1]}}, a_w};
  assign pb      = {{XLEN{b_msign & b_w[XLEN-1]}}, b_w};
  assign prod_c  = pa * pb;

  generate
    if (MUL_LAT == 1) begin : g_comb
      assign prod_r = prod_c;
      assign mop    = muldiv_op_e'(in_op);
      assign mword  = in_word;
    end else begin : g_ret
      logic [2*XLEN-1:0] ret [MUL_LAT-1];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < MUL_LAT - 1; i++) ret[i] <= '0;
        end else begin
          ret[0] <= prod_c;
          for (int i = 1; i < MUL_LAT - 1; i++) ret[i] <= ret[i-1];
        end
      end
      assign prod_r = ret[MUL_LAT-2];
      assign mop    = op_q;
      assign mword  = word_q;
    end
  endgenerate

  assign mul_res = (mop == OP_MUL) ? wfix(prod_r[XLEN-1:0], mword) : prod_r[2*XLEN-1:XLEN];

  // Divide: magnitudes into the iterator, signs restored when entering DONE
  logic            sa, sb, b_zero, ovf, div_start, div_done;
  logic [XLEN-1:0] mag_a, mag_b, spec_res, div_quo, div_rem, q_s, r_s, div_res;
  logic [CW-1:0]   n_bits;

  assign sa        = div_signed & a_w[XLEN-1];
  assign sb        = div_signed & b_w[XLEN-1];
  assign mag_a     = sa ? -a_w : a_w;
  assign mag_b     = sb ? -b_w : b_w;
  assign b_zero    = (b_w == '0);
  assign ovf       = div_signed & (a_w == (in_word ? MIN_W : MIN_X)) & (&b_w);
  assign spec_res  = wfix(in_op[1] ? (b_zero ? a_w : '0) : (b_zero ? '1 : a_w), in_word);
  assign n_bits    = in_word ? CW'(32) : CW'(XLEN);
  assign div_start = in_valid & in_ready & is_div & ~err_in & ~b_zero & ~ovf;

  muldiv_div_iter #(.W(XLEN), .CW(CW)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .n_bits   (n_bits),
    .dividend (mag_a),
    .divisor  (mag_b),
    .done     (div_done),
    .quo      (div_quo),
    .rem      (div_rem)
  );

  assign q_s     = neg_q ? -div_quo : div_quo;
  assign r_s     = sa_q ? -div_rem : div_rem;
  assign div_res = wfix(is_rem_q ? r_s : q_s, word_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
      op_q       <= OP_MUL;
      word_q     <= 1'b0;
      is_rem_q   <= 1'b0;
      sa_q       <= 1'b0;
      neg_q      <= 1'b0;
      tag_q      <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          op_q     <= muldiv_op_e'(in_op);
          word_q   <= in_word;
          is_rem_q <= in_op[1];
          sa_q     <= sa;
          neg_q    <= sa ^ sb;
          tag_q    <= in_tag;
          if (err_in || (is_div && (b_zero || ovf)) || (!is_div && MUL_LAT == 1)) begin
            state      <= ST_DONE;
            out_valid  <= 1'b1;
            out_tag    <= in_tag;
            out_err    <= err_in;
            out_result <= err_in ? '0 : (is_div ? spec_res : mul_res);
          end else if (is_div) begin
            state <= ST_DIV;
          end else begin
            state <= ST_MUL;
            cnt   <= MCW'(MUL_LAT - 2);
          end
        end
        ST_MUL: if (cnt == '0) begin
          state      <= ST_DONE;
          out_valid  <= 1'b1;
          out_tag    <= tag_q;
          out_err    <= 1'b0;
          out_result <= mul_res;
        end else begin
          cnt <= cnt - MCW'(1);
        end
        ST_DIV: if (div_done) begin
          state      <= ST_DONE;
          out_valid  <= 1'b1;
          out_tag    <= tag_q;
          out_err    <= 1'b0;
          out_result <= div_res;
        end
        ST_DONE: if (out_ready) begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (XLEN=64, MUL_LAT=2) with hand-computed results.
module tb_alu_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = '0;
  logic        in_word = 1'b0;
  logic [63:0] in_a = '0, in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic [4:0]  out_tag;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.XLEN(64), .MUL_LAT(2), .TAG_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_err    (out_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents the request for exactly one accept edge
  task automatic send(input logic [2:0] op, input logic w, input logic [63:0] a,
                      input logic [63:0] b, input logic [4:0] tag);
    in_valid = 1'b1; in_op = op; in_word = w; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic w,
                     input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                     input logic [63:0] exp_res, input int exp_lat, input logic exp_err);
    int lat;
    send(op, w, a, b, tag);
    wait_valid(lat);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " result"}, out_result, exp_res);
    chk({name, " tag"}, 64'(out_tag), 64'(tag));
    chk({name, " err"}, 64'(out_err), 64'(exp_err));
    handshake();
    chk({name, " valid drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset result", out_result, 64'd0);
    chk("reset tag", 64'(out_tag), 64'd0);
    chk("reset err", 64'(out_err), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run("MUL", OP_MUL, 1'b0, 64'd7, -64'sd3, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 2, 1'b0);
    run("MULHU", OP_MULHU, 1'b0, '1, '1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 2, 1'b0);
    run("MULH", OP_MULH, 1'b0, '1, '1, 5'd3, 64'd0, 2, 1'b0);
    run("MULHSU", OP_MULHSU, 1'b0, '1, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1'b0);
    run("MULW", OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 2, 1'b0);

    run("DIV", OP_DIV, 1'b0, -64'sd20, 64'd3, 5'd6, -64'sd6, 65, 1'b0);
    run("REM", OP_REM, 1'b0, -64'sd20, 64'd3, 5'd7, -64'sd2, 65, 1'b0);
    run("DIVUW", OP_DIVU, 1'b1, 64'hFFFF_FFFF, 64'd2, 5'd8, 64'h0000_0000_7FFF_FFFF, 33, 1'b0);
    run("REMU", OP_REMU, 1'b0, 64'd100, 64'd7, 5'd9, 64'd2, 65, 1'b0);

    run("DIV0", OP_DIV, 1'b0, 64'd5, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0);
    run("REMU0", OP_REMU, 1'b0, 64'd5, 64'd0, 5'd11, 64'd5, 1, 1'b0);
    run("DIVW ovf", OP_DIV, 1'b1, 64'h8000_0000, '1, 5'd12, 64'hFFFF_FFFF_8000_0000, 1, 1'b0);
    run("REMW ovf", OP_REM, 1'b1, 64'h8000_0000, '1, 5'd13, 64'd0, 1, 1'b0);
    run("DIV ovf", OP_DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 5'd14, 64'h8000_0000_0000_0000, 1, 1'b0);

    // Backpressure: result held while the consumer stalls
    send(OP_MUL, 1'b0, 64'd6, 64'd7, 5'd9);
    wait_valid(lat);
    chk("bp latency", 64'(lat), 64'd2);
    repeat (10) begin
      @(negedge clk);
      chk("bp valid", 64'(out_valid), 64'd1);
      chk("bp result", out_result, 64'd42);
      chk("bp tag", 64'(out_tag), 64'd9);
      chk("bp in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp in_ready after", 64'(in_ready), 64'd1);
    @(negedge clk);
    run("DIV after bp", OP_DIV, 1'b0, -64'sd7, 64'd2, 5'd3, -64'sd3, 65, 1'b0);

    // Reset in the middle of a divide
    send(OP_DIV, 1'b0, 64'd1000, 64'd3, 5'd17);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst mid valid", 64'(out_valid), 64'd0);
    chk("rst mid in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run("DIVU post-rst", OP_DIVU, 1'b0, 64'd100, 64'd7, 5'd18, 64'd14, 65, 1'b0);

    run("MULHW err", OP_MULH, 1'b1, 64'd3, 64'd4, 5'd19, 64'd0, 1, 1'b1);
    run("MULHUW err", OP_MULHU, 1'b1, '1, '1, 5'd20, 64'd0, 1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised multi-cycle M-extension execution unit for the RV64 core. It sits beside the single-cycle integer ALU and handles MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and their W forms. It uses a valid/ready handshake on input and output, and an iterative restoring divider. It also implements the RISC-V divide-by-zero and signed-overflow results.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64. W ops are legal only when XLEN=64.
MUL_LAT, 2, cycles from accept to out_valid for multiply ops; minimum 1.
TAG_W, 5, width of the destination-register tag carried alongside the op.

Ports:
clk  in  1  core clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  request present
in_ready  out  1  unit can accept a request (state IDLE)
in_op  in  3  muldiv_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7
in_word  in  1  W variant: 32-bit operands, result sign-extended from bit 31
in_a  in  XLEN  rs1 value
in_b  in  XLEN  rs2 value
in_tag  in  TAG_W  rd index, returned unchanged
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
out_result  out  XLEN  result
out_tag  out  TAG_W  tag of the result
out_err  out  1  in_word=1 with MULH/MULHSU/MULHU, or in_word=1 with XLEN=32; result forced to 0

Behaviour:
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, out_err=0. Counters and operand registers are cleared. Reset during MUL or DIV abandons the operation and produces no output.
- Accept rule: a request is accepted on an edge where in_valid && in_ready. All inputs are latched on that edge (T0). in_ready is combinational and equals (state==IDLE).
- FSM states:
  - IDLE: on accept, go to MUL, DIV or DONE.
  - MUL: count MUL_LAT-1 cycles, then go to DONE.
  - DIV: one quotient bit per cycle for N cycles (N=32 if in_word, else XLEN), then go to DONE.
  - DONE: out_valid=1. Return to IDLE on the edge where out_ready=1.
  - A new request can be accepted no earlier than the cycle after the DONE handshake; there is no back-to-back overlap.
- Latency from T0:
  - out_valid rises at T0+MUL_LAT for multiplies.
  - out_valid rises at T0+N+1 for normal divides.
  - out_valid rises at T0+1 for special cases and error ops; these go straight from IDLE to DONE.
- Output stability: out_result, out_tag and out_err hold stable while out_valid && !out_ready.
- Operand preparation, W forms: use a[31:0] and b[31:0]. Sign-extend them for DIV/REM/MUL and zero-extend them for DIVU/REMU.
- Multiply:
  - Form the full 2*XLEN product with signed×signed, signed×unsigned or unsigned×unsigned operands as the op requires.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
  - MULW sign-extends product[31:0].
  - Timing closure is achieved with MUL_LAT-1 retiming registers after the product.
- Divide:
  - Operate on magnitudes with a restoring algorithm, shifting the remainder and quotient registers one bit per cycle.
  - Quotient sign = sa^sb; remainder sign = sa.
  - Signs are applied in the cycle the FSM enters DONE.
- Special cases, detected at accept:
  - b==0: quotient = all ones; remainder = a.
  - Signed overflow (a = most-negative value, b = -1, both at operand width): quotient = a; remainder = 0.
  - W results are then sign-extended from bit 31.
- DIVU/REMU by 0: quotient = 2^XLEN-1, or 0xFFFFFFFF sign-extended for W forms.
- in_op values outside the enum cannot occur, since the field is 3 bits and fully decoded.

Decomposition:
- Package muldiv_pkg holds:
  - muldiv_op_e
  - FSM state enum
  - helper function sext32
  - localparams for the most-negative value per width
- One natural sub-module, muldiv_div_iter. It holds the restoring divider datapath (remainder/quotient registers and a bit counter) with start/done, and is instantiated once with width XLEN.

Test Plan:
1. XLEN=64, MUL_LAT=2: MUL a=7, b=-3 -> out_valid at T0+2, result 0xFFFFFFFFFFFFFFEB; MULHU a=b=0xFFFFFFFFFFFFFFFF -> 0xFFFFFFFFFFFFFFFE.
2. DIV a=-20, b=3 -> result -6 at T0+65; REM with the same operands -> -2; DIVUW a=0xFFFFFFFF, b=2 -> 0x000000007FFFFFFF at T0+33.
3. DIV a=5, b=0 -> 0xFFFFFFFFFFFFFFFF at T0+1; REMU a=5, b=0 -> 5; DIVW a=0x80000000, b=-1 -> 0xFFFFFFFF80000000; REMW with the same operands -> 0.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> result and tag stable, in_ready=0 throughout; raise out_ready -> in_ready=1 on the next cycle, and a second request is accepted and correct.
5. Assert reset 20 cycles into a DIV -> out_valid=0 and in_ready=1 immediately; the next DIVU 100/7 returns 14 with no stale data.
6. MULHW with in_word=1 -> out_err=1, result 0, at T0+1.
